// File: rtl/lc3_pkg.sv
// Shared constants and state encodings for the LC-3 arithmetic helper units
// (sequential multiplier and divider).
package lc3_pkg;

    // Default operand width of the shift-add multiplier.
    localparam int MUL_WIDTH = 16;

    // Multiplier control states; the encoding is fixed so other blocks and
    // debug tooling can decode the state register directly.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Divider constants shared with the restoring divider.
    localparam int DIV_WIDTH = 16;
    localparam int DIV_STEPS = DIV_WIDTH;

    // Bits needed for a step counter that must hold values 0..steps.
    function automatic int cnt_bits(input int steps);
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One iteration of the shift-add multiplier: conditional add of the
// multiplicand into the upper half, then a one-bit right shift of the
// combined {carry, accumulator, multiplier} value.
module mul_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mplier_next
);

    // The add result is WIDTH+1 bits so the carry out survives into the shift.
    logic [WIDTH:0] sum;

    // Add when the current multiplier LSB is set, then shift carry/acc/mplier right.
    always_comb begin
        sum = {1'b0, acc};
        if (mplier[0]) begin
            sum = sum + {1'b0, mcand};
        end
        acc_next    = sum[WIDTH:1];
        mplier_next = {sum[0], mplier[WIDTH-1:1]};
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential unsigned shift-add multiplier. One product bit per cycle:
// an accepted start is followed by WIDTH RUN cycles and one DONE cycle.
module mul_seq
    import lc3_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mul_state_t state;
    mul_state_t state_next;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplier_next;
    logic [CNT_W-1:0] step_cnt;
    logic             last_step;

    assign last_step = (step_cnt == LAST_STEP);

    mul_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mcand      (mcand),
        .acc        (acc),
        .mplier     (mplier),
        .acc_next   (acc_next),
        .mplier_next(mplier_next)
    );

    // Next-state logic: start only matters in IDLE, DONE always lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset wins over everything, including a pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: load operands on accept, step during RUN, capture product on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            step_cnt <= '0;
            product  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand    <= multiplicand;
                        mplier   <= multiplier;
                        acc      <= '0;
                        step_cnt <= '0;
                    end
                end
                RUN: begin
                    acc      <= acc_next;
                    mplier   <= mplier_next;
                    step_cnt <= step_cnt + CNT_W'(1);
                    if (last_step) begin
                        product <= {acc_next, mplier_next};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags are flopped from the next state so they carry no combinational input paths.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: table vectors, random operands against an
// arithmetic reference, and hand-written multi-cycle corner sequences.
module tb_mul_seq;

    localparam int W       = 16;
    localparam int LATENCY = 17;
    localparam int PERIOD  = 18;
    localparam int BOUND   = 40;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic [2*W-1:0] product;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    mul_seq #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .product     (product),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a sequence wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: plain unsigned multiplication in 2*W bits.
    function automatic logic [2*W-1:0] refMul(input logic [W-1:0] a, input logic [W-1:0] b);
        return (2*W)'(a) * (2*W)'(b);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge of the first busy cycle.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count cycles (first busy cycle = 1) until done; lat = -1 on timeout.
    task automatic waitDone(output int lat, output int busyCnt);
        lat     = -1;
        busyCnt = 0;
        for (int i = 1; i <= BOUND; i++) begin
            if (i > 1) @(negedge clk);
            if (busy) busyCnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    // Full single operation with latency, busy, product, pulse and hold checks.
    task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] expected);
        int lat;
        int busyCnt;
        applyStimulus(a, b);
        waitDone(lat, busyCnt);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(LATENCY));
        checkOutput({tag, "_busycycles"}, 64'(busyCnt), 64'(LATENCY));
        checkOutput({tag, "_product"}, 64'(product), 64'(expected));
        @(negedge clk);
        checkOutput({tag, "_donepulse"}, 64'(done), 64'(0));
        checkOutput({tag, "_busyidle"}, 64'(busy), 64'(0));
        repeat (3) @(negedge clk);
        checkOutput({tag, "_hold"}, 64'(product), 64'(expected));
    endtask

    initial begin
        int lat;
        int doneCnt;
        int busySeen;
        int firstT;
        int secondT;
        logic [2*W-1:0] p1;
        logic [2*W-1:0] p2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{16'hE7B3, 16'h00B2, 32'h00A11A76};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h0000, 16'h1234, 32'h00000000};
        vecs[3] = '{16'h1234, 16'h0000, 32'h00000000};
        vecs[4] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[5] = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[6] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};

        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_product", 64'(product), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod);
        end

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 10; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            runOp($sformatf("rand%0d", i), ra, rb, refMul(ra, rb));
        end

        // A second start during RUN (with new operands) must be ignored.
        applyStimulus(16'd3, 16'd5);
        doneCnt = 0;
        lat     = -1;
        p1      = '0;
        for (int i = 1; i <= BOUND; i++) begin
            if (i > 1) @(negedge clk);
            if (i == 3) begin
                start        = 1'b1;
                multiplicand = 16'd7;
                multiplier   = 16'd9;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                doneCnt++;
                if (lat < 0) begin
                    lat = i;
                    p1  = product;
                end
            end
        end
        checkOutput("ignore_donecount", 64'(doneCnt), 64'(1));
        checkOutput("ignore_latency", 64'(lat), 64'(LATENCY));
        checkOutput("ignore_product", 64'(p1), 64'(refMul(16'd3, 16'd5)));

        // start held high: back-to-back operations with operands changed mid-run.
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 16'd2;
        multiplier   = 16'd3;
        @(negedge clk);
        multiplicand = 16'd4;
        multiplier   = 16'd5;
        firstT  = -1;
        secondT = -1;
        p1      = '0;
        p2      = '0;
        for (int i = 1; i <= 3 * BOUND; i++) begin
            if (i > 1) @(negedge clk);
            if (done) begin
                if (firstT < 0) begin
                    firstT = i;
                    p1     = product;
                end else begin
                    secondT = i;
                    p2      = product;
                    start   = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        checkOutput("b2b_first_latency", 64'(firstT), 64'(LATENCY));
        checkOutput("b2b_spacing", 64'(secondT - firstT), 64'(PERIOD));
        checkOutput("b2b_product1", 64'(p1), 64'(refMul(16'd2, 16'd3)));
        checkOutput("b2b_product2", 64'(p2), 64'(refMul(16'd4, 16'd5)));
        repeat (2) @(negedge clk);
        checkOutput("b2b_idle_after", 64'(busy), 64'(0));

        // Reset mid-run, with a simultaneous start that must be ignored.
        applyStimulus(16'hE7B3, 16'h00B2);
        repeat (6) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        checkOutput("abort_product", 64'(product), 64'(0));
        doneCnt  = 0;
        busySeen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
            if (busy) busySeen++;
        end
        checkOutput("abort_nodone", 64'(doneCnt), 64'(0));
        checkOutput("abort_nobusy", 64'(busySeen), 64'(0));
        runOp("after_abort", 16'h1234, 16'h5678, refMul(16'h1234, 16'h5678));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
